pwr_cntr_bank: RTL and testbench

Parametrised bank of saturating transition counters for switching-activity (power) estimation. Each of `NCH` monitored 1-bit signals gets its own `CW`-bit counter that increments on every toggle while counting is enabled. Counters are read one at a time through a registered address/data port and cleared individually or all at once. The bank sits beside the library gates in the test harness and replaces the fixed-size, memory-backed counter store with a synthesizable block.

---
 rtl/pwr_cntr_pkg.sv | 26 ++
 rtl/pwr_cntr_cell.sv | 44 ++++
 rtl/pwr_cntr_bank.sv | 102 ++++++++++
 tb/tb_pwr_cntr_bank.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwr_cntr_pkg.sv
// pwr_cntr_pkg: shared defaults and helpers for the transition-counter bank.
// Provides the default geometry, an address-width helper and the saturation value.
package pwr_cntr_pkg;

  localparam int DEF_NCH = 5;
  localparam int DEF_CW  = 32;

  // Smallest address width (at least 1) that can index n channels.
  function automatic int addr_bits(input int n);
    int b;
    b = 1;
    while ((1 << b) < n) b = b + 1;
    return b;
  endfunction

  localparam int DEF_AW = addr_bits(DEF_NCH);

  // All-ones value of width cw, returned right-aligned in 64 bits (cw <= 64).
  function automatic logic [63:0] sat_value(input int cw);
    logic [63:0] v;
    if (cw >= 64) v = '1;
    else          v = (64'd1 << cw) - 64'd1;
    return v;
  endfunction

endpackage

// File: rtl/pwr_cntr_cell.sv
// pwr_cntr_cell: one monitored channel.
// Holds the edge register, the saturating toggle counter and the sticky overflow flag.
module pwr_cntr_cell
  import pwr_cntr_pkg::*;
#(
  parameter int CW = DEF_CW
) (
  input  logic          CLK,
  input  logic          RESET_L,
  input  logic          cnt_en,
  input  logic          sig,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          ovf
);

  localparam logic [CW-1:0] SAT = CW'(sat_value(CW));

  logic sig_q;
  logic toggle;

  assign toggle = sig ^ sig_q;

  // Previous-cycle copy of the signal; tracks even while counting is disabled.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) sig_q <= 1'b0;
    else          sig_q <= sig;
  end

  // Counter with clear priority, hold at all-ones and sticky overflow on a dropped toggle.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (cnt_en && toggle) begin
      if (cnt == SAT) ovf <= 1'b1;
      else            cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/pwr_cntr_bank.sv
// pwr_cntr_bank: bank of NCH saturating toggle counters with a registered read port.
// Optional macro PWR_CNTR_SNAPSHOT_EN adds a SNAP input and a shadow copy that reads return.
module pwr_cntr_bank
  import pwr_cntr_pkg::*;
#(
  parameter int NCH = DEF_NCH,
  parameter int CW  = DEF_CW,
  parameter int AW  = addr_bits(NCH)
) (
  input  logic           CLK,
  input  logic           RESET_L,
  input  logic           ENB,
  input  logic [NCH-1:0] SIG,
  input  logic           RD_EN,
  input  logic [AW-1:0]  RD_ADDR,
  output logic [CW-1:0]  RD_DATA,
  output logic           RD_VALID,
  output logic           RD_ERR,
  input  logic           CLR_EN,
  input  logic [AW-1:0]  CLR_ADDR,
  input  logic           CLR_ALL,
  output logic [NCH-1:0] OVF
`ifdef PWR_CNTR_SNAPSHOT_EN
  ,
  input  logic           SNAP
`endif
);

  logic [CW-1:0]  cnt [NCH];
  logic [NCH-1:0] clr;
  logic           primed;
  logic           cnt_en;
  logic [CW-1:0]  rd_mux;
  logic           rd_hit;

  assign cnt_en = ENB & primed;

  // Ignore the first cycle after reset so the zeroed edge registers cannot fake a toggle.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) primed <= 1'b0;
    else          primed <= 1'b1;
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign clr[i] = CLR_ALL | (CLR_EN & (CLR_ADDR == AW'(i)));

    pwr_cntr_cell #(
      .CW(CW)
    ) u_cell (
      .CLK    (CLK),
      .RESET_L(RESET_L),
      .cnt_en (cnt_en),
      .sig    (SIG[i]),
      .clr    (clr[i]),
      .cnt    (cnt[i]),
      .ovf    (OVF[i])
    );
  end

`ifdef PWR_CNTR_SNAPSHOT_EN
  logic [CW-1:0] shadow [NCH];

  // Coherent copy of all live counters, taken from pre-edge values; clears leave it alone.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      for (int i = 0; i < NCH; i++) shadow[i] <= '0;
    end else if (SNAP) begin
      for (int i = 0; i < NCH; i++) shadow[i] <= cnt[i];
    end
  end
`endif

  // Select the addressed channel; unmatched addresses yield zero and no hit.
  always_comb begin
    rd_mux = '0;
    rd_hit = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (RD_ADDR == AW'(i)) begin
        rd_hit = 1'b1;
`ifdef PWR_CNTR_SNAPSHOT_EN
        rd_mux = shadow[i];
`else
        rd_mux = cnt[i];
`endif
      end
    end
  end

  // One-cycle read pipeline; data holds between reads, valid/err are single-cycle strobes.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      RD_DATA  <= '0;
      RD_VALID <= 1'b0;
      RD_ERR   <= 1'b0;
    end else begin
      RD_VALID <= RD_EN;
      RD_ERR   <= RD_EN & ~rd_hit;
      if (RD_EN) RD_DATA <= rd_mux;
    end
  end

endmodule

// File: tb/tb_pwr_cntr_bank.sv
// tb_pwr_cntr_bank: scoreboard bench for pwr_cntr_bank with NCH=5, CW=4.
// Builds with or without PWR_CNTR_SNAPSHOT_EN; the reference model follows the macro.
module tb_pwr_cntr_bank;

  localparam int NCH = 5;
  localparam int CW  = 4;
  localparam int AW  = 3;

  logic           CLK;
  logic           RESET_L;
  logic           ENB;
  logic [NCH-1:0] SIG;
  logic           RD_EN;
  logic [AW-1:0]  RD_ADDR;
  logic [CW-1:0]  RD_DATA;
  logic           RD_VALID;
  logic           RD_ERR;
  logic           CLR_EN;
  logic [AW-1:0]  CLR_ADDR;
  logic           CLR_ALL;
  logic [NCH-1:0] OVF;
`ifdef PWR_CNTR_SNAPSHOT_EN
  logic           SNAP;
`endif

  typedef struct {
    logic [CW-1:0] data;
    logic          err;
    int            cycle;
  } rd_exp_t;

  rd_exp_t sb[$];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic [CW-1:0]  m_cnt    [NCH];
  logic [CW-1:0]  m_shadow [NCH];
  logic [NCH-1:0] m_ovf;
  logic [NCH-1:0] m_sigq;
  logic           m_primed;
  logic [CW-1:0]  last_rd;
  logic [NCH-1:0] s;

  pwr_cntr_bank #(
    .NCH(NCH),
    .CW (CW),
    .AW (AW)
  ) dut (
    .CLK     (CLK),
    .RESET_L (RESET_L),
    .ENB     (ENB),
    .SIG     (SIG),
    .RD_EN   (RD_EN),
    .RD_ADDR (RD_ADDR),
    .RD_DATA (RD_DATA),
    .RD_VALID(RD_VALID),
    .RD_ERR  (RD_ERR),
    .CLR_EN  (CLR_EN),
    .CLR_ADDR(CLR_ADDR),
    .CLR_ALL (CLR_ALL),
    .OVF     (OVF)
`ifdef PWR_CNTR_SNAPSHOT_EN
    ,
    .SNAP    (SNAP)
`endif
  );

  // Free-running clock.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Cycle counter used to measure read latency.
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors = vectors + 1;
    if (obs !== exp) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Retire expected reads when the DUT strobes RD_VALID; flag missing or extra strobes.
  always @(negedge CLK) begin
    rd_exp_t e;
    if (RESET_L === 1'b1) begin
      if (RD_VALID === 1'b1) begin
        if (sb.size() == 0) begin
          checkOutput("rd_valid_spurious", 32'(RD_VALID), 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("rd_data", 32'(RD_DATA), 32'(e.data));
          checkOutput("rd_err", 32'(RD_ERR), 32'(e.err));
          checkOutput("rd_latency", 32'(cyc - e.cycle), 32'd1);
          last_rd = e.data;
        end
      end else if (sb.size() != 0 && sb[0].cycle + 1 <= cyc) begin
        void'(sb.pop_front());
        checkOutput("rd_valid_missing", 32'(RD_VALID), 32'd1);
      end
    end
  end

  task automatic resetModel();
    for (int i = 0; i < NCH; i++) begin
      m_cnt[i]    = '0;
      m_shadow[i] = '0;
    end
    m_ovf    = '0;
    m_sigq   = '0;
    m_primed = 1'b0;
    last_rd  = '0;
  endtask

  // Drive one cycle of inputs, queue any expected read result, advance the model.
  task automatic applyStimulus(input logic [NCH-1:0] sig, input logic enb, input logic rd,
                               input logic [AW-1:0] raddr, input logic clren,
                               input logic [AW-1:0] caddr, input logic clrall, input logic snap);
    rd_exp_t e;
    logic tgl;
    logic clr;
    SIG      = sig;
    ENB      = enb;
    RD_EN    = rd;
    RD_ADDR  = raddr;
    CLR_EN   = clren;
    CLR_ADDR = caddr;
    CLR_ALL  = clrall;
`ifdef PWR_CNTR_SNAPSHOT_EN
    SNAP     = snap;
`endif
    if (rd) begin
      e.err   = (int'(raddr) >= NCH);
      e.cycle = cyc;
      e.data  = '0;
      if (!e.err) begin
`ifdef PWR_CNTR_SNAPSHOT_EN
        e.data = m_shadow[raddr];
`else
        e.data = m_cnt[raddr];
`endif
      end
      sb.push_back(e);
    end
    if (snap) begin
      for (int i = 0; i < NCH; i++) m_shadow[i] = m_cnt[i];
    end
    for (int i = 0; i < NCH; i++) begin
      tgl = sig[i] ^ m_sigq[i];
      clr = clrall || (clren && int'(caddr) == i);
      if (clr) begin
        m_cnt[i] = '0;
        m_ovf[i] = 1'b0;
      end else if (enb && m_primed && tgl) begin
        if (m_cnt[i] == {CW{1'b1}}) m_ovf[i] = 1'b1;
        else                        m_cnt[i] = m_cnt[i] + CW'(1);
      end
    end
    m_sigq   = sig;
    m_primed = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(s, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic readCh(input int a);
    applyStimulus(s, 1'b1, 1'b1, AW'(a), 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic toggleCh(input int ch, input logic enb, input int n);
    for (int k = 0; k < n; k++) begin
      s[ch] = ~s[ch];
      applyStimulus(s, enb, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    end
  endtask

  task automatic doReset(input logic [NCH-1:0] sig);
    RESET_L  = 1'b0;
    SIG      = sig;
    ENB      = 1'b1;
    RD_EN    = 1'b0;
    RD_ADDR  = '0;
    CLR_EN   = 1'b0;
    CLR_ADDR = '0;
    CLR_ALL  = 1'b0;
`ifdef PWR_CNTR_SNAPSHOT_EN
    SNAP     = 1'b0;
`endif
    sb.delete();
    resetModel();
    s = sig;
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("rst_rd_data", 32'(RD_DATA), 32'd0);
    checkOutput("rst_rd_valid", 32'(RD_VALID), 32'd0);
    checkOutput("rst_rd_err", 32'(RD_ERR), 32'd0);
    checkOutput("rst_ovf", 32'(OVF), 32'd0);
    RESET_L = 1'b1;
  endtask

  // Main sequence.
  initial begin
    // Reset with all signals high, then let the block prime without toggles.
    doReset(5'b11111);
    idle(3);
    for (int a = 0; a < NCH; a++) readCh(a);
    idle(2);
    checkOutput("prime_ovf", 32'(OVF), 32'(m_ovf));

    // Ten toggles on channel 2, read every channel back to back.
    toggleCh(2, 1'b1, 10);
    for (int a = 0; a < NCH; a++) readCh(a);
    readCh(2);
    idle(3);
    checkOutput("rd_hold", 32'(RD_DATA), 32'(last_rd));

    // Toggles while disabled are lost for good.
    toggleCh(0, 1'b0, 4);
    toggleCh(0, 1'b1, 3);
    readCh(0);

    // Saturation: overflow rises on the first dropped toggle, not before.
    toggleCh(1, 1'b1, 15);
    checkOutput("ovf_at_max", 32'(OVF), 32'(m_ovf));
    toggleCh(1, 1'b1, 5);
    checkOutput("ovf_sat", 32'(OVF), 32'(m_ovf));
    readCh(1);
    applyStimulus(s, 1'b1, 1'b0, '0, 1'b1, 3'd1, 1'b0, 1'b0);
    readCh(1);
    checkOutput("ovf_cleared", 32'(OVF), 32'(m_ovf));

    // Read and clear in the same cycle, then an out-of-range clear.
    applyStimulus(s, 1'b1, 1'b1, 3'd2, 1'b1, 3'd2, 1'b0, 1'b0);
    readCh(2);
    applyStimulus(s, 1'b1, 1'b0, '0, 1'b1, 3'd7, 1'b0, 1'b0);
    readCh(0);

    // Clear-all beats a same-cycle toggle; out-of-range read.
    toggleCh(3, 1'b1, 2);
    s[3] = ~s[3];
    applyStimulus(s, 1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    readCh(3);
    readCh(0);
    readCh(6);
    readCh(7);

    // Snapshot sequence on channel 4.
    toggleCh(4, 1'b1, 7);
    applyStimulus(s, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    toggleCh(4, 1'b1, 5);
    readCh(4);
    applyStimulus(s, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    readCh(4);
    idle(2);

    // Reset lands while a read is in flight; the read must be dropped.
    RD_EN   = 1'b1;
    RD_ADDR = 3'd4;
    #3;
    doReset(s);
    idle(1);
    readCh(4);
    readCh(0);
    idle(3);
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
